// File: rtl/exhaustive_pkg.sv
// Shared types and constants for the exhaustive vector generator and its MISR.
// Build option: define GRAY_SEQ_EN to emit Gray-coded vectors instead of binary.
package exhaustive_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One signature step: shift left, fold the feedback polynomial on carry-out, absorb the response.
  function automatic logic [15:0] misrStep(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ d;
  endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register; clr reloads the seed, en absorbs din.
module misr16
  import exhaustive_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  logic [15:0] r_sig;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sig <= MISR_SEED;
    end else if (en) begin
      r_sig <= misrStep(r_sig, din);
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/exhaustive_vec_gen.sv
// Sweeps every N_IN-bit vector, holding each for HOLD cycles, and compacts the responses into a MISR.
// Build option: GRAY_SEQ_EN selects Gray-coded vec; otherwise vec is the binary index.
module exhaustive_vec_gen
  import exhaustive_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int HOLD   = 20,
  parameter int RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [RESP_W-1:0] resp,
  output logic [N_IN-1:0]   vec,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sig
);

  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;

  state_t          r_state;
  state_t          w_next;
  logic [N_IN-1:0] r_idx;
  logic [HW-1:0]   r_hcnt;
  logic            w_sample;
  logic            w_launch;
  logic [15:0]     w_din;

  assign w_sample = (r_state == ST_RUN) && (r_hcnt == HOLD_LAST);
  assign w_launch = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !abort;
  assign w_din    = 16'(resp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_launch) w_next = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_sample && (r_idx == IDX_LAST)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_launch) begin
          w_next = ST_RUN;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // IDLE is only ever entered with idx cleared, so vec reads 0 there without extra gating.
  always_ff @(posedge clk) begin
    if (rst || w_launch || abort) begin
      r_idx  <= '0;
      r_hcnt <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_sample) begin
        r_hcnt <= '0;
        if (r_idx != IDX_LAST) begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  misr16 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (w_launch),
    .en  (w_sample && !abort),
    .din (w_din),
    .sig (sig)
  );

`ifdef GRAY_SEQ_EN
  assign vec = r_idx ^ (r_idx >> 1);
`else
  assign vec = r_idx;
`endif

  assign busy      = (r_state == ST_RUN);
  assign vec_valid = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_exhaustive_vec_gen.sv
// Scoreboard bench for exhaustive_vec_gen: a sweep-position model predicts every cycle, a monitor compares.
// A second tiny instance (N_IN=1, HOLD=1) checks the known signature sequence FFFF -> EFDF -> CF9F.
module tb_exhaustive_vec_gen;

  localparam int N_IN   = 4;
  localparam int HOLD   = 20;
  localparam int RESP_W = 2;
  localparam int NV     = 1 << N_IN;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [RESP_W-1:0] resp = '0;
  logic [N_IN-1:0]   vec;
  logic              vecValid;
  logic              busy;
  logic              done;
  logic [15:0]       sig;

  logic        rstS = 1'b1;
  logic        startS = 1'b0;
  logic        abortS = 1'b0;
  logic [1:0]  respS = 2'b00;
  logic [0:0]  vecS;
  logic        vecValidS;
  logic        busyS;
  logic        doneS;
  logic [15:0] sigS;

  always #5 clk = ~clk;

  exhaustive_vec_gen #(.N_IN(N_IN), .HOLD(HOLD), .RESP_W(RESP_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp),
    .vec(vec), .vec_valid(vecValid), .busy(busy), .done(done), .sig(sig)
  );

  exhaustive_vec_gen #(.N_IN(1), .HOLD(1), .RESP_W(2)) u_small (
    .clk(clk), .rst(rstS), .start(startS), .abort(abortS), .resp(respS),
    .vec(vecS), .vec_valid(vecValidS), .busy(busyS), .done(doneS), .sig(sigS)
  );

  typedef struct packed {
    logic [N_IN-1:0] vec;
    logic            vld;
    logic            busy;
    logic            done;
    logic [15:0]     sig;
  } obs_t;

  obs_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Model: mode 0=idle 1=run 2=done, mPos = cycles elapsed in the current sweep.
  int          mMode = 0;
  int          mPos = 0;
  logic [15:0] mSig = 16'hFFFF;

  function automatic logic [N_IN-1:0] encVec(input int i);
    logic [N_IN-1:0] b;
    b = N_IN'(i);
`ifdef GRAY_SEQ_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [15:0] refMisr(input logic [15:0] s, input logic [RESP_W-1:0] r);
    int v;
    v = (int'(s) * 2) % 65536;
    if (s >= 16'h8000) v = v ^ 'h1021;
    v = v ^ int'(r);
    return 16'(v);
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic a);
    obs_t e;
    @(negedge clk);
    rst   = r;
    start = s;
    abort = a;
    resp  = RESP_W'($urandom);
    if (r) begin
      mMode = 0; mPos = 0; mSig = 16'hFFFF;
    end else begin
      case (mMode)
        0: if (s && !a) begin mMode = 1; mPos = 0; mSig = 16'hFFFF; end
        1: begin
          if (a) begin
            mMode = 0; mPos = 0;
          end else begin
            if (mPos % HOLD == HOLD - 1) mSig = refMisr(mSig, resp);
            mPos++;
            if (mPos == NV * HOLD) mMode = 2;
          end
        end
        default: begin
          if (a) begin
            mMode = 0; mPos = 0;
          end else if (s) begin
            mMode = 1; mPos = 0; mSig = 16'hFFFF;
          end
        end
      endcase
    end
    e.vec  = (mMode == 1) ? encVec(mPos / HOLD) : (mMode == 2) ? encVec(NV - 1) : '0;
    e.vld  = (mMode == 1);
    e.busy = (mMode == 1);
    e.done = (mMode == 2);
    e.sig  = mSig;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a = {vec, vecValid, busy, done, sig};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL cycle t=%0t got vec=%h vld=%b busy=%b done=%b sig=%h, want vec=%h vld=%b busy=%b done=%b sig=%h",
               $time, a.vec, a.vld, a.busy, a.done, a.sig, e.vec, e.vld, e.busy, e.done, e.sig);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    int wait_cnt;

    @(posedge clk); #1;
    checkValue("small_reset_sig", 32'(sigS), 32'hFFFF);
    checkValue("small_reset_vec", 32'(vecS), 32'h0);
    @(negedge clk); rstS = 1'b0; startS = 1'b1;
    @(posedge clk); #1;
    checkValue("small_run_busy", 32'(busyS), 32'h1);
    checkValue("small_run_sig", 32'(sigS), 32'hFFFF);
    @(negedge clk); startS = 1'b0;
    @(posedge clk); #1;
    checkValue("small_sig1", 32'(sigS), 32'hEFDF);
    checkValue("small_busy1", 32'(busyS), 32'h1);
    @(posedge clk); #1;
    checkValue("small_sig2", 32'(sigS), 32'hCF9F);
    checkValue("small_done", 32'(doneS), 32'h1);
    checkValue("small_vec_final", 32'(vecS), 32'h1);

    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (NV * HOLD + 5) applyStimulus(1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (5 * HOLD + 3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3 * HOLD) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (6 * HOLD + 4) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 300) == 0, ($urandom % 10) == 0, ($urandom % 60) == 0);
    end

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (NV * HOLD + 2) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    wait_cnt = 0;
    while (expQ.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain got=%0d pending want=0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
